// File: rtl/gnn_pkg.sv
// Shared constants and types for the 4-node GNN dense-layer MAC scheduler.
package gnn_pkg;

  localparam int unsigned NUM_NODES = 4;
  localparam int unsigned NUM_IN    = 4;
  localparam int unsigned NUM_HID   = 4;
  localparam int unsigned NUM_OUT   = 2;
  localparam int unsigned DW        = 5;
  localparam int unsigned HID_W     = 12;
  localparam int unsigned ACC_W     = 21;

  typedef enum logic [1:0] {
    StIdle,
    StL1,
    StL2,
    StFin
  } state_e;

  typedef logic signed [DW-1:0]    feat_t;
  typedef logic signed [HID_W-1:0] hid_t;
  typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/gnn_mac_unit.sv
// Shared signed multiply-accumulate: sum_o is the running total including this cycle's product.
module gnn_mac_unit
  import gnn_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  logic  first_i,
  input  hid_t  a_i,
  input  feat_t b_i,
  output acc_t  sum_o
);

  acc_t prod;
  acc_t acc_q;

  always_comb begin
    prod  = acc_t'(a_i) * acc_t'(b_i);
    sum_o = (first_i ? acc_t'(0) : acc_q) + prod;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/gnn_mac_scheduler.sv
// Drives one shared MAC through layer 1 (4->4 per node) and layer 2 (4->2 per node),
// holding hidden activations locally and streaming per-node outputs with sticky ready flags.
module gnn_mac_scheduler
  import gnn_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_ready_i,
  input  logic                   stall_i,
  output logic [1:0]             feat_node_o,
  output logic [1:0]             feat_idx_o,
  input  logic [DW-1:0]          feat_data_i,
  output logic                   w_layer_o,
  output logic [1:0]             w_row_o,
  output logic [1:0]             w_col_o,
  input  logic [DW-1:0]          w_data_i,
  output logic                   busy_o,
  output logic                   out_valid_o,
  output logic [1:0]             out_node_o,
  output logic                   out_idx_o,
  output logic [ACC_W-1:0]       out_data_o,
  output logic [2*NUM_NODES-1:0] out_ready_o,
  output logic                   done_o
);

  state_e             state_q;
  logic [1:0]         node_q;
  logic [1:0]         outer_q;  // hidden unit j in L1, output k in L2
  logic [1:0]         term_q;   // input i in L1, hidden unit j in L2
  hid_t               hid_q [NUM_NODES][NUM_HID];
  logic               busy_q;
  logic               out_valid_q;
  logic [1:0]         out_node_q;
  logic               out_idx_q;
  acc_t               out_data_q;
  logic [2*NUM_NODES-1:0] out_ready_q;
  logic               done_q;

  logic  in_l1;
  logic  in_l2;
  logic  mac_en;
  logic  last_term;
  hid_t  mac_a;
  feat_t mac_b;
  acc_t  mac_sum;

  always_comb begin
    in_l1     = (state_q == StL1);
    in_l2     = (state_q == StL2);
    mac_en    = (in_l1 || in_l2) && !stall_i;
    last_term = (term_q == 2'd3);
    mac_a     = in_l2 ? hid_q[node_q][term_q] : hid_t'(feat_t'(feat_data_i));
    mac_b     = feat_t'(w_data_i);
  end

  gnn_mac_unit u_mac (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (mac_en),
    .first_i (term_q == 2'd0),
    .a_i     (mac_a),
    .b_i     (mac_b),
    .sum_o   (mac_sum)
  );

  // Address outputs follow the loop counters directly; they only move when sequencing does.
  always_comb begin
    feat_node_o = in_l1 ? node_q : 2'd0;
    feat_idx_o  = in_l1 ? term_q : 2'd0;
    w_layer_o   = in_l2;
    w_row_o     = (in_l1 || in_l2) ? term_q : 2'd0;
    w_col_o     = (in_l1 || in_l2) ? outer_q : 2'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      node_q      <= '0;
      outer_q     <= '0;
      term_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_node_q  <= '0;
      out_idx_q   <= 1'b0;
      out_data_q  <= '0;
      out_ready_q <= '0;
      done_q      <= 1'b0;
      for (int n = 0; n < NUM_NODES; n++) begin
        for (int j = 0; j < NUM_HID; j++) begin
          hid_q[n][j] <= '0;
        end
      end
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (!stall_i) begin
        unique case (state_q)
          StIdle: begin
            if (in_ready_i) begin
              state_q     <= StL1;
              busy_q      <= 1'b1;
              out_ready_q <= '0;
              node_q      <= '0;
              outer_q     <= '0;
              term_q      <= '0;
            end
          end
          StL1: begin
            term_q <= term_q + 2'd1;
            if (last_term) begin
              hid_q[node_q][outer_q] <= mac_sum[HID_W-1:0];
              outer_q                <= outer_q + 2'd1;
              if (outer_q == 2'd3) begin
                node_q <= node_q + 2'd1;
                if (node_q == 2'd3) begin
                  state_q <= StL2;
                end
              end
            end
          end
          StL2: begin
            term_q <= term_q + 2'd1;
            if (last_term) begin
              out_valid_q                         <= 1'b1;
              out_node_q                          <= node_q;
              out_idx_q                           <= outer_q[0];
              out_data_q                          <= mac_sum;
              out_ready_q[{node_q, outer_q[0]}]   <= 1'b1;
              if (outer_q[0]) begin
                outer_q <= 2'd0;
                node_q  <= node_q + 2'd1;
                if (node_q == 2'd3) begin
                  state_q <= StFin;
                  done_q  <= 1'b1;
                end
              end else begin
                outer_q <= 2'd1;
              end
            end
          end
          StFin: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o      = busy_q;
  assign out_valid_o = out_valid_q;
  assign out_node_o  = out_node_q;
  assign out_idx_o   = out_idx_q;
  assign out_data_o  = out_data_q;
  assign out_ready_o = out_ready_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_gnn_mac_scheduler.sv
// Directed + randomized bench for gnn_mac_scheduler against an arithmetic reference of both layers.
module tb_gnn_mac_scheduler;

  logic        clk;
  logic        rst_n;
  logic        in_ready;
  logic        stall;
  logic [1:0]  feat_node, feat_idx, w_row, w_col, out_node;
  logic [4:0]  feat_data, w_data;
  logic        w_layer, busy, out_valid, out_idx, done;
  logic [20:0] out_data;
  logic [7:0]  out_ready;

  logic [4:0]  feat_mem [4][4];
  logic [4:0]  w_mem    [2][4][4];
  logic [20:0] exp_out  [8];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  assign feat_data = feat_mem[feat_node][feat_idx];
  assign w_data    = w_mem[w_layer][w_row][w_col];

  gnn_mac_scheduler dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_ready_i  (in_ready),
    .stall_i     (stall),
    .feat_node_o (feat_node),
    .feat_idx_o  (feat_idx),
    .feat_data_i (feat_data),
    .w_layer_o   (w_layer),
    .w_row_o     (w_row),
    .w_col_o     (w_col),
    .w_data_i    (w_data),
    .busy_o      (busy),
    .out_valid_o (out_valid),
    .out_node_o  (out_node),
    .out_idx_o   (out_idx),
    .out_data_o  (out_data),
    .out_ready_o (out_ready),
    .done_o      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: all ones; 1: ones with layer-2 weights -1; 2: everything -16; 3: random
  task automatic load(input int mode);
    int h [4][4];
    int s, a, b;
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++)
        feat_mem[n][i] = (mode == 0 || mode == 1) ? 5'd1 : (mode == 2) ? 5'b10000 : 5'($urandom);
    for (int l = 0; l < 2; l++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          w_mem[l][r][c] = (mode == 0) ? 5'd1 : (mode == 1) ? ((l == 0) ? 5'd1 : 5'b11111) :
                           (mode == 2) ? 5'b10000 : 5'($urandom);
    for (int n = 0; n < 4; n++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int i = 0; i < 4; i++) begin
          a = $signed(feat_mem[n][i]);
          b = $signed(w_mem[0][i][j]);
          s += a * b;
        end
        h[n][j] = s;
      end
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 2; k++) begin
        s = 0;
        for (int j = 0; j < 4; j++) begin
          b = $signed(w_mem[1][j][k]);
          s += h[n][j] * b;
        end
        exp_out[2*n+k] = s[20:0];
      end
  endtask

  // Cycle c is the clock period after edge c-1; edge 0 samples the start request.
  task automatic run(input string tag, input int ss, input int sl, input int spur,
                     input int abort_at, input bit started, input bit chain);
    int          ev;
    int          done_seen;
    int          end_c;
    logic [20:0] last;
    ev        = 0;
    done_seen = 0;
    last      = '0;
    end_c     = 98 + sl;
    if (!started) begin
      @(negedge clk);
      in_ready = 1'b1;
    end
    @(posedge clk);
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({tag, ".busy_start"}, 32'(busy), 32'd1);
        chk({tag, ".ready_cleared"}, 32'(out_ready), 32'd0);
      end
      if (out_valid) begin
        if (ev < 8) begin
          chk({tag, ".valid_cycle"}, c, 69 + 4 * ev + sl);
          chk({tag, ".out_node"}, 32'(out_node), ev / 2);
          chk({tag, ".out_idx"}, 32'(out_idx), ev % 2);
          chk({tag, ".out_data"}, 32'(out_data), 32'(exp_out[ev]));
          chk({tag, ".out_ready"}, 32'(out_ready), (32'd1 << (ev + 1)) - 1);
        end else begin
          chk({tag, ".extra_valid"}, ev, 7);
        end
        last = exp_out[ev % 8];
        ev++;
      end else if (ev > 0) begin
        chk({tag, ".data_hold"}, 32'(out_data), 32'(last));
      end
      if (done) begin
        chk({tag, ".done_cycle"}, c, 97 + sl);
        chk({tag, ".done_with_valid"}, 32'(out_valid), 32'd1);
        done_seen++;
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, ".abort_busy"}, 32'(busy), 32'd0);
        chk({tag, ".abort_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".abort_ready"}, 32'(out_ready), 32'd0);
        chk({tag, ".abort_done"}, 32'(done), 32'd0);
        in_ready = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (c == end_c) begin
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ".strobe_count"}, ev, 8);
        chk({tag, ".done_count"}, done_seen, 1);
        chk({tag, ".ready_held"}, 32'(out_ready), 32'hFF);
        in_ready = chain;
        stall    = 1'b0;
      end else begin
        in_ready = (c == spur);
        stall    = (c >= ss) && (c < ss + sl);
      end
    end
  endtask

  initial begin
    int ss, sl;
    rst_n    = 1'b0;
    in_ready = 1'b0;
    stall    = 1'b0;
    load(0);
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);
    chk("rst.ready", 32'(out_ready), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.addr", {24'd0, feat_node, feat_idx, w_layer, w_row[0], w_col}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    load(0);
    run("ones", 0, 0, 0, 0, 1'b0, 1'b0);
    load(1);
    run("neg_l2", 0, 0, 0, 0, 1'b0, 1'b0);
    load(2);
    run("min_all", 0, 0, 0, 0, 1'b0, 1'b0);
    load(3);
    run("stall10", 30, 10, 0, 0, 1'b0, 1'b0);
    load(3);
    run("spurious", 0, 0, 40, 0, 1'b0, 1'b1);
    load(3);
    run("chained", 0, 0, 0, 0, 1'b1, 1'b0);
    load(3);
    run("abort", 0, 0, 0, 70, 1'b0, 1'b0);
    load(3);
    run("after_abort", 0, 0, 0, 0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      ss = $urandom_range(2, 50);
      sl = $urandom_range(1, 12);
      load(3);
      run("rand_stall", ss, sl, 0, 0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gnn_mac_scheduler.md
Name: gnn_mac_scheduler

Overview:
- Sequences a single shared signed multiply-accumulate unit through the two dense layers of the 4-node GNN accelerator.
- Layer 1 is 4 features -> 4 hidden units per node. Layer 2 is 4 hidden units -> 2 outputs per node.
- It addresses the upstream feature and weight register files and holds the hidden activations internally.
- It streams the 21-bit per-node outputs with per-output ready flags to the top-level output registers. Graph aggregation is done upstream.

Parameters:
- NUM_NODES, 4, nodes processed per run
- NUM_IN, 4, input features per node
- NUM_HID, 4, hidden units per node
- NUM_OUT, 2, outputs per node
- DW, 5, feature/weight width (signed two's complement)
- HID_W, 12, hidden activation width (signed)
- ACC_W, 21, output width (signed)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_ready  in  1  start request, sampled in IDLE
- stall  in  1  freeze all sequencing this cycle (register-file contention)
- feat_node  out  2  feature read node index
- feat_idx  out  2  feature read index
- feat_data  in  DW  feature value, combinational from feat_node/feat_idx
- w_layer  out  1  weight bank select (0 = layer 1 w04..w37, 1 = layer 2 w48..w79)
- w_row  out  2  weight source index
- w_col  out  2  weight destination index (layer 2 uses 0..1)
- w_data  in  DW  weight value, combinational
- busy  out  1  run in progress
- out_valid  out  1  one-cycle output strobe
- out_node  out  2  node of out_data
- out_idx  out  1  output index (0 = out0, 1 = out1)
- out_data  out  ACC_W  output value
- out_ready  out  8  sticky flags, bit 2*n+k set when out{k}_node{n} has been produced
- done  out  1  one-cycle end-of-run pulse

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=IDLE, counters 0, hidden buffer 0.
- FSM states: IDLE, L1, L2, FIN.
- IDLE:
  - in_ready=1 -> L1 next cycle, busy=1, out_ready cleared to 0.
  - in_ready while busy is ignored.
- L1: node n 0..3 (outer), hidden j 0..3, term i 0..3 (inner).
  - Address outputs: feat=(n,i), weight=(0,i,j).
  - prod = sext(feat_data) * sext(w_data), 10-bit signed.
  - acc = (i==0 ? 0 : acc) + prod.
  - On i==3, hid[n][j] is written with the completed sum (12-bit signed, no saturation, no activation).
  - 64 active cycles, then -> L2.
- L2: node n (outer), output k 0..1, term j 0..3.
  - Operand is hid[n][j], with weight=(1,j,k); feature address outputs held at 0.
  - prod = hid * sext(w_data).
  - Same accumulate rule; accumulator sign-extended to ACC_W.
  - On j==3, next cycle: out_valid=1, out_node=n, out_idx=k, out_data=sum, out_ready[2n+k] set.
  - Output order: (0,0),(0,1),(1,0)..(3,1).
  - 32 active cycles, then -> FIN.
- out_data holds its last value between strobes.
- stall=1: counters, accumulator, FSM and hidden buffer are frozen; address outputs held.
  - A pending out_valid still issues (it is registered from the previous cycle).
  - No new out_valid is generated during stall.
  - Each stall cycle delays completion by one cycle.
- Latency (no stall): in_ready sampled at edge 0 -> first MAC cycle 1 -> L1 cycles 1-64, L2 cycles 65-96.
  - out_valid in cycles 69, 73, ..., 97.
  - FIN in cycle 97: done=1 coincident with the last out_valid.
  - busy=0 from cycle 98; IDLE accepts a new in_ready in cycle 98.
- out_ready holds after done until the next accepted start.
- Reset mid-run aborts immediately to reset values; no partial outputs are retained.
- Arithmetic wraps in two's complement. Widths are chosen so the full input range cannot overflow.

Decomposition:
- Package gnn_pkg:
  - NUM_* and width constants
  - state enum typedef (IDLE, L1, L2, FIN)
  - typedefs feat_t (signed DW), hid_t (signed HID_W), acc_t (signed ACC_W)
- One sub-module gnn_mac_unit: signed multiplier plus accumulator, with clear-on-first and enable inputs.

Test Plan:
- All features 1, all weights 1, in_ready pulse -> every hidden = 4; eight out_valid strobes at cycles 69..97 in (n,k) order, each out_data = 16; out_ready = 8'hFF; done at 97.
- Same, but layer-2 weights 5'b11111 (-1) -> every out_data = 21'h1FFFF0 (-16).
- Features 5'b10000, all weights 5'b10000 -> hidden = 1024; out_data = 21'h1F0000 (-65536); no overflow.
- stall held for 10 cycles starting at cycle 30 -> identical values; first out_valid at 79, done at 107.
- in_ready re-asserted at cycle 40 -> ignored, single run, done at 97; in_ready at 98 -> new run, out_ready cleared at 99.
- rst_n low at cycle 70 -> immediately busy=0, out_valid=0, out_ready=0; the next start completes a full, correct run.
